// File: rtl/mmio_pkg.sv
// Shared definitions for the store-side memory map: address constants,
// target encoding shared with the load path, and FSM state encodings.
package mmio_pkg;

    localparam logic [15:0] SERIAL_DATA_ADDR  = 16'hBF00;
    localparam logic [15:0] SERIAL_STATE_ADDR = 16'hBF01;
    localparam logic [15:0] GFX_ADDR          = 16'hBF0A;

    typedef enum logic [1:0] {
        RAM              = 2'b00,
        GRAPHIC_CARD     = 2'b01,
        SERIALPORT_DATA  = 2'b10,
        SERIALPORT_STATE = 2'b11
    } target_e;

    typedef enum logic [1:0] {
        RAM_IDLE,
        RAM_SETUP,
        RAM_PULSE,
        RAM_HOLD
    } ram_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT
    } tx_state_e;

    // Exact match on one of the device addresses; everything else is SRAM.
    function automatic target_e decode_target(
        input logic [15:0] addr,
        input logic [15:0] sdata_addr,
        input logic [15:0] sstate_addr,
        input logic [15:0] gfx_addr
    );
        if (addr == sdata_addr)       return SERIALPORT_DATA;
        else if (addr == sstate_addr) return SERIALPORT_STATE;
        else if (addr == gfx_addr)    return GRAPHIC_CARD;
        else                          return RAM;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO buffering serial transmit data between CPU stores and the UART.
module tx_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [7:0]                   wdata_i,
    input  logic                         pop_i,
    output logic [7:0]                   rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_store_unit.sv
// Store-side memory map: routes CPU stores to SRAM, the serial transmit FIFO
// or the graphic register, and stalls the pipeline while a store is pending.
module mmio_store_unit #(
    parameter int unsigned WE_CYCLES         = 1,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter logic [15:0] SERIAL_DATA_ADDR  = mmio_pkg::SERIAL_DATA_ADDR,
    parameter logic [15:0] SERIAL_STATE_ADDR = mmio_pkg::SERIAL_STATE_ADDR,
    parameter logic [15:0] GFX_ADDR          = mmio_pkg::GFX_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        stall,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_wdata_oe,
    output logic        ram_ce_n,
    output logic        ram_we_n,
    output logic        ram_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        tx_can_write,
    output logic [15:0] gfx_data,
    output logic        gfx_we
);

    import mmio_pkg::*;

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WE_CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    target_e             tgt_c;
    ram_state_e          ram_state_q, ram_state_d;
    tx_state_e           tx_state_q, tx_state_d;
    logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;
    logic [15:0]         ram_addr_q, ram_addr_d;
    logic [15:0]         ram_wdata_q, ram_wdata_d;
    logic                ram_ce_n_q, ram_we_n_q, ram_oe_q, ram_busy_q;
    logic [15:0]         gfx_data_q, gfx_data_d;
    logic                gfx_we_q, gfx_we_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q;
    logic                tx_first_q, tx_first_d;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]          fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;

    assign tgt_c = decode_target(wr_addr, SERIAL_DATA_ADDR, SERIAL_STATE_ADDR, GFX_ADDR);

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (wr_data[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Store decode and SRAM write sequencer; requests are only taken in IDLE.
    always_comb begin
        ram_state_d = ram_state_q;
        we_cnt_d    = we_cnt_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        gfx_data_d  = gfx_data_q;
        gfx_we_d    = 1'b0;
        fifo_push   = 1'b0;
        stall       = 1'b0;
        unique case (ram_state_q)
            RAM_IDLE: begin
                if (wr_req) begin
                    unique case (tgt_c)
                        RAM: begin
                            ram_addr_d  = wr_addr;
                            ram_wdata_d = wr_data;
                            stall       = 1'b1;
                            ram_state_d = RAM_SETUP;
                        end
                        SERIALPORT_DATA: begin
                            if (fifo_full) stall     = 1'b1;
                            else           fifo_push = 1'b1;
                        end
                        GRAPHIC_CARD: begin
                            gfx_we_d   = 1'b1;
                            gfx_data_d = wr_data;
                        end
                        default: ;
                    endcase
                end
            end
            RAM_SETUP: begin
                stall       = 1'b1;
                we_cnt_d    = '0;
                ram_state_d = RAM_PULSE;
            end
            RAM_PULSE: begin
                stall = 1'b1;
                if (we_cnt_q == WE_CNT_W'(WE_CYCLES - 1)) ram_state_d = RAM_HOLD;
                else                                      we_cnt_d    = we_cnt_q + WE_CNT_W'(1);
            end
            RAM_HOLD: ram_state_d = RAM_IDLE;
            default:  ram_state_d = RAM_IDLE;
        endcase
    end

    // UART drain; the first TX_WAIT cycle covers the transmitter's busy latency.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_first_d = tx_first_q;
        fifo_pop   = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_rdata;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_first_d = 1'b1;
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_first_q)    tx_first_d = 1'b0;
                else if (!tx_busy) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_state_q <= RAM_IDLE;
            tx_state_q  <= TX_IDLE;
            we_cnt_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_ce_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
            ram_oe_q    <= 1'b0;
            ram_busy_q  <= 1'b0;
            gfx_data_q  <= '0;
            gfx_we_q    <= 1'b0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            tx_first_q  <= 1'b0;
        end else begin
            ram_state_q <= ram_state_d;
            tx_state_q  <= tx_state_d;
            we_cnt_q    <= we_cnt_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_ce_n_q  <= (ram_state_d == RAM_IDLE);
            ram_we_n_q  <= (ram_state_d != RAM_PULSE);
            ram_oe_q    <= (ram_state_d != RAM_IDLE);
            ram_busy_q  <= (ram_state_d != RAM_IDLE);
            gfx_data_q  <= gfx_data_d;
            gfx_we_q    <= gfx_we_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= (tx_state_d == TX_START);
            tx_first_q  <= tx_first_d;
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign ram_ce_n     = ram_ce_n_q;
    assign ram_we_n     = ram_we_n_q;
    assign ram_wdata_oe = ram_oe_q;
    assign ram_busy     = ram_busy_q;
    assign gfx_data     = gfx_data_q;
    assign gfx_we       = gfx_we_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign tx_can_write = (fifo_count != CNT_W'(FIFO_DEPTH));

endmodule

// File: doc/mmio_store_unit.md
Name: mmio_store_unit

Overview:
- Write-direction counterpart of the CPU load-side memory map.
- Decodes CPU store requests from the MEM stage and routes each one to a single target:
  - external SRAM, using a multi-cycle CE/WE write sequence;
  - serial transmit byte FIFO, which drains into the UART transmitter through a start/busy handshake;
  - graphic-card register.
- Stalls the pipeline while a store cannot complete. Also exports transmit-ready status for the serial state register.

Parameters:
- WE_CYCLES, 1: number of cycles ram_we_n is held low (>=1).
- FIFO_DEPTH, 4: transmit FIFO entries; must be a power of two, >=2.
- SERIAL_DATA_ADDR, 16'hBF00: serial data address; a store here enqueues a transmit byte.
- SERIAL_STATE_ADDR, 16'hBF01: serial state address; read-only, so stores here are dropped.
- GFX_ADDR, 16'hBF0A: graphic-card register address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- wr_req  in  1  store request; held with addr/data by the CPU while stall=1.
- wr_addr  in  16  store virtual address.
- wr_data  in  16  store data.
- stall  out  1  freeze the pipeline this cycle.
- ram_addr  out  16  SRAM address, latched.
- ram_wdata  out  16  SRAM write data, latched.
- ram_wdata_oe  out  1  tristate enable for the SRAM data bus.
- ram_ce_n  out  1  SRAM chip enable, active-low.
- ram_we_n  out  1  SRAM write enable, active-low.
- ram_busy  out  1  SRAM bus owned by this block; the read side must not drive it.
- tx_data  out  8  byte presented to the UART transmitter.
- tx_start  out  1  one-cycle launch pulse.
- tx_busy  in  1  transmitter busy.
- tx_can_write  out  1  FIFO not full; feeds serial state bit0.
- gfx_data  out  16  graphic register value.
- gfx_we  out  1  one-cycle write strobe.

Behaviour:
- Reset values:
  - stall=0, ram_wdata_oe=0, ram_ce_n=1, ram_we_n=1, ram_busy=0.
  - ram_addr=0, ram_wdata=0.
  - tx_data=0, tx_start=0, tx_can_write=1.
  - gfx_data=0, gfx_we=0.
  - FIFO empty; both FSMs in their IDLE state.
- Decode is combinational on wr_addr. Equality with one of the three constants selects that target; every other address selects RAM.
- RAM FSM (states IDLE, SETUP, PULSE, HOLD):
  - IDLE & wr_req & RAM target: latch addr/data, stall=1 (combinational, same cycle), go to SETUP.
  - SETUP: ce_n=0, we_n=1, oe=1, busy=1, stall=1. Lasts 1 cycle, then PULSE.
  - PULSE: ce_n=0, we_n=0, oe=1, stall=1, for WE_CYCLES cycles (counter), then HOLD.
  - HOLD: we_n=1, ce_n=0, oe=1, busy=1, stall=0. The CPU advances at this edge; next state is IDLE.
  - stall is therefore high for 2+WE_CYCLES cycles per RAM store.
  - A new request is never sampled in HOLD; back-to-back stores restart from IDLE.
- Serial store (IDLE & wr_req & SERIAL_DATA_ADDR):
  - If count<FIFO_DEPTH: push wr_data[7:0] at the edge, stall=0.
  - Otherwise stall=1 until a slot frees. Full status uses the registered count, so a pop in the same cycle does not clear stall until the next cycle.
- SERIAL_STATE_ADDR store: no effect, stall=0.
- GFX store:
  - gfx_data is registered from wr_data and gfx_we=1 for exactly the following cycle.
  - stall=0.
  - A held wr_req produces only one strobe per accepted store: the CPU moves on because stall=0.
- Drain FSM (states TX_IDLE, TX_START, TX_WAIT):
  - TX_IDLE & FIFO non-empty & !tx_busy: pop head into tx_data, go to TX_START.
  - TX_START: tx_start=1 for one cycle, then TX_WAIT.
  - TX_WAIT: ignore tx_busy for the first cycle (transmitter raise latency), then wait for tx_busy=0 and return to TX_IDLE.
  - Bytes go out in FIFO order. tx_data is stable from TX_START until the next pop.
- FIFO:
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle keep count unchanged.
  - tx_can_write = (count != FIFO_DEPTH).
- Reset mid-operation: an in-flight SRAM write is aborted; we_n/ce_n go high and oe goes low asynchronously. The FIFO is flushed and a pending tx_start is cancelled.

Decomposition:
- Shared package mmio_pkg holds:
  - address constants SERIAL_DATA_ADDR, SERIAL_STATE_ADDR, GFX_ADDR;
  - target encoding RAM=2'b00, GRAPHIC_CARD=2'b01, SERIALPORT_DATA=2'b10, SERIALPORT_STATE=2'b11, the same encoding the load path uses;
  - RAM FSM and drain FSM state encodings.
- One sub-module, tx_byte_fifo, parameterised by depth. It provides push/pop/full/empty/count and 8-bit data.

Test Plan:
- RAM store: WE_CYCLES=1, store 16'h1234 to 16'h0040 -> stall high 3 cycles; ram_addr=0040 and ram_wdata=1234 throughout; we_n low exactly 1 cycle, framed by ce_n low for SETUP, PULSE and HOLD; back to IDLE.
- Serial order: stores 8'h41, 8'h42, 8'h43 to BF00 with tx_busy modelled as 10 cycles -> no stall; tx_start pulses three times with tx_data 41, 42, 43 in order.
- FIFO full: depth 4, transmitter held busy, five stores to BF00 -> first four stall=0; fifth stalls and tx_can_write=0; release busy -> fifth accepted the cycle after the pop is registered.
- GFX and state writes: store 16'h00FF to BF0A -> gfx_we one cycle, gfx_data=00FF. Store to BF01 -> no output change, stall=0.
- Boundary decode: stores to BF02 and BF09 -> RAM sequence at those addresses.
- Reset during PULSE -> we_n=1, ce_n=1, ram_wdata_oe=0 immediately, without waiting for a clock; FIFO empty; tx_can_write=1.
